store_buffer: RTL and testbench

Posted-write store buffer sitting directly upstream of the data memory. It absorbs word stores from the core into a small FIFO and drains them to memory one per cycle whenever memory signals readiness. Loads are served by forwarding from the youngest matching buffered store so that read-after-write order is preserved. The core stalls only when the buffer is full.

---
 rtl/store_buffer_pkg.sv | 27 ++
 rtl/store_buffer_forward_match.sv | 48 ++++
 rtl/store_buffer.sv | 107 ++++++++++
 tb/tb_store_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer_pkg
// Description : Core-wide memory-path definitions shared by the store buffer
//               and its forwarding matcher: address/data widths, the buffered
//               entry record and the word-index slice helper.
// Revision    : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int C_AW = 32;
    localparam int C_DW = 32;

    // One buffered store: full byte address (low bits kept for the memory
    // port) plus the write data.
    typedef struct packed {
        logic [C_AW-1:0] addr;
        logic [C_DW-1:0] data;
    } entry_t;

    // All accesses are full words, so only bits [AW-1:2] identify a location.
    function automatic logic [C_AW-3:0] word_idx(input logic [C_AW-1:0] a);
        return a[C_AW-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_forward_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_forward_match
// Description : DEPTH-way word-index compare of a load address against the
//               buffered stores, returning the youngest matching entry.
// Ports       : entries - buffered store records
//               valid   - per-entry occupancy
//               wr_ptr  - next write slot (youngest entry is wr_ptr-1)
//               ld_addr - load byte address
//               hit     - some valid entry matches ld_addr's word
//               data    - data of youngest match, 0 when no hit
// Revision    : 1.0 - initial release
// ============================================================================
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  entry_t                     entries [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [C_AW-1:0]            ld_addr,
    output logic                       hit,
    output logic [C_DW-1:0]            data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] w_idx;

    // Walk from oldest (wr_ptr-DEPTH) to youngest (wr_ptr-1); a later match
    // overwrites an earlier one, so the youngest store wins.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = wr_ptr - PW'(k);
            if (valid[w_idx] &&
                (word_idx(entries[w_idx].addr) == word_idx(ld_addr))) begin
                hit  = 1'b1;
                data = entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Posted-write store buffer in front of the data memory. Stores
//               are queued in a circular FIFO and drained one per cycle when
//               memory is ready; loads forward from the youngest matching
//               buffered store.
// Ports       : st_valid/st_addr/st_data/st_ready - core store request
//               ld_addr/ld_hit/ld_data            - load forwarding lookup
//               mem_ready/mem_we/mem_addr/mem_wdata - memory write port
//               empty/count                       - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    // Widths are tied to the shared entry record; keep them at the package
    // values.
    parameter int AW    = C_AW,
    parameter int DW    = C_DW
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        st_valid,
    input  logic [AW-1:0]               st_addr,
    input  logic [DW-1:0]               st_data,
    output logic                        st_ready,
    input  logic [AW-1:0]               ld_addr,
    output logic                        ld_hit,
    output logic [DW-1:0]               ld_data,
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    entry_t           r_entry [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;

    // Full check uses registered count only: a same-cycle pop does not
    // open a slot for the incoming store.
    assign st_ready  = (r_count != c_full);
    assign empty     = (r_count == '0);
    assign mem_we    = !empty && mem_ready;
    assign count     = r_count;
    // Head entry is shown even when empty; its contents stay as last written.
    assign mem_addr  = r_entry[r_rd_ptr].addr;
    assign mem_wdata = r_entry[r_rd_ptr].data;

    assign w_push    = st_valid && st_ready;
    assign w_pop     = mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Push and pop never target the same slot: push requires a free
            // slot and pop requires an occupied one.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_entry[r_wr_ptr] <= '{addr: st_addr, data: st_data};
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH)
    ) u_forward (
        .entries (r_entry),
        .valid   (r_valid),
        .wr_ptr  (r_wr_ptr),
        .ld_addr (ld_addr),
        .hit     (ld_hit),
        .data    (ld_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk;
    logic           rst_n;
    logic           st_valid;
    logic [AW-1:0]  st_addr;
    logic [DW-1:0]  st_data;
    logic           st_ready;
    logic [AW-1:0]  ld_addr;
    logic           ld_hit;
    logic [DW-1:0]  ld_data;
    logic           mem_ready;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           empty;
    logic [CW-1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] wlog [$];
    logic [AW+DW-1:0] mq   [$];

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .empty     (empty),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each memory write mid-cycle; it commits at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] mr_pat;
        logic [15:0] sv_pat;
        logic        exp_ready;
        logic        exp_we;

        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ld_addr   = '0;
        mem_ready = 1'b1;

        // ---------------- reset state ----------------
        #23;
        check("rst_st_ready",  st_ready,  1);
        check("rst_empty",     empty,     1);
        check("rst_count",     count,     0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_ld_hit",    ld_hit,    0);
        check("rst_ld_data",   ld_data,   0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("idle_st_ready", st_ready, 1);
            check("idle_empty",    empty,    1);
            check("idle_count",    count,    0);
            check("idle_mem_we",   mem_we,   0);
            tick();
        end

        // ---------------- single store, 1-cycle latency ----------------
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
        #1;
        check("single_pre_we", mem_we, 0);
        tick();
        st_valid = 1'b0;
        #1;
        check("single_we",    mem_we,    1);
        check("single_addr",  mem_addr,  32'h10);
        check("single_wdata", mem_wdata, 32'hDEADBEEF);
        check("single_count", count,     1);
        tick();
        check("single_empty", empty,  1);
        check("single_we_off", mem_we, 0);

        // ---------------- fill, hold off, drain order ----------------
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), 32'hA0 + 32'(i));
        #1;
        check("full_count", count,    4);
        check("full_ready", st_ready, 0);
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h55;
        tick();
        check("held_count", count, 4);
        wlog.delete();
        mem_ready = 1'b1;
        #1;
        check("drain0_we",    mem_we,   1);
        check("drain0_ready", st_ready, 0);
        tick();
        check("drain1_count", count,    3);
        check("drain1_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        check("drain2_count", count, 3);
        tick(); tick(); tick();
        check("drain_empty", empty, 1);
        check("drain_nwrites", wlog.size(), 5);
        if (wlog.size() == 5) begin
            for (int i = 0; i < 4; i++)
                check("drain_order", wlog[i], {32'h100 + 32'(4*i), 32'hA0 + 32'(i)});
            check("drain_order5", wlog[4], {32'h200, 32'h55});
        end
        mem_ready = 1'b0;

        // ---------------- forwarding ----------------
        push(32'h20, 32'd1);
        push(32'h20, 32'd2);
        push(32'h24, 32'd3);
        ld_addr = 32'h22; #1;
        check("fwd_22_hit",  ld_hit,  1);
        check("fwd_22_data", ld_data, 2);
        ld_addr = 32'h30; #1;
        check("fwd_30_hit",  ld_hit,  0);
        check("fwd_30_data", ld_data, 0);
        ld_addr = 32'h27; #1;
        check("fwd_27_data", ld_data, 3);
        ld_addr = 32'h30;
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'd9; #1;
        check("fwd_same_cycle_hit", ld_hit, 0);
        tick();
        st_valid = 1'b0; #1;
        check("fwd_next_hit",  ld_hit,  1);
        check("fwd_next_data", ld_data, 9);
        check("fwd_count",     count,   4);
        mem_ready = 1'b1; ld_addr = 32'h20; #1;
        check("fwd_popping_data", ld_data, 2);
        tick(); tick(); tick(); tick();
        check("fwd_drained", empty, 1);

        // ---------------- wrap with reference queue ----------------
        mem_ready = 1'b0;
        mq.delete();
        for (int i = 0; i < 4; i++) begin
            push(32'h300 + 32'(4*i), 32'h2000 + 32'(i));
            mq.push_back({32'h300 + 32'(4*i), 32'h2000 + 32'(i)});
        end
        mr_pat = 16'b1011_0111_1101_1110;
        sv_pat = 16'b1111_0110_1111_1011;
        for (int c = 0; c < 16; c++) begin
            mem_ready = mr_pat[c];
            st_valid  = sv_pat[c];
            st_addr   = 32'h400 + 32'(4*c);
            st_data   = 32'h1000 + 32'(c);
            #1;
            exp_ready = (mq.size() != DEPTH);
            exp_we    = (mq.size() != 0) && mr_pat[c];
            check("wrap_ready", st_ready, exp_ready);
            check("wrap_we",    mem_we,   exp_we);
            if (exp_we) check("wrap_head", {mem_addr, mem_wdata}, mq[0]);
            tick();
            if (exp_we) void'(mq.pop_front());
            if (sv_pat[c] && exp_ready) mq.push_back({st_addr, st_data});
            check("wrap_count", count, mq.size());
        end
        st_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < DEPTH && mq.size() != 0; c++) begin
            #1;
            check("wrap_tail_head", {mem_addr, mem_wdata}, mq[0]);
            tick();
            void'(mq.pop_front());
        end
        check("wrap_empty", empty, 1);

        // ---------------- reset mid-drain ----------------
        mem_ready = 1'b0;
        push(32'h500, 32'h11);
        push(32'h504, 32'h22);
        push(32'h508, 32'h33);
        mem_ready = 1'b1;
        #1;
        check("mid_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("mid_we_after", mem_we, 0);
        check("mid_count",    count,  0);
        check("mid_empty",    empty,  1);
        wlog.delete();
        tick();
        #3;
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("mid_no_writes", wlog.size(), 0);
        check("mid_ld_hit",    ld_hit,      0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
